// File: rtl/regpair_seq.sv
// regpair_seq: 16-bit register-pair INC/DEC/LDI/MOV micro-sequencer.
// Each command writes two bytes, low then high, carrying between them.
module regpair_seq #(
  parameter int NPAIRS = 6
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [2:0]  i_cmd_dst,
  input  logic [2:0]  i_cmd_src,
  input  logic [15:0] i_cmd_imm,
  output logic        o_done,
  output logic        o_err,
  output logic        o_wrap,
  output logic [7:0]  o_rf_dat,
  output logic        o_rf_load,
  output logic [3:0]  o_rf_load_sel,
  output logic [3:0]  o_rf_rd_sel,
  input  logic [7:0]  i_rf_rd
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_MOV = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  dst_q, dst_d;
  logic [2:0]  src_q, src_d;
  logic [15:0] imm_q, imm_d;
  logic        cy_q, cy_d;
  logic        err_q, err_d;
  logic        wrap_q, wrap_d;
  logic        done_q, done_d;

  logic [2:0]  rp;
  logic        bad;
  logic        rd_ff;
  logic        rd_00;
  logic        is_inc;
  logic        is_dec;

  assign rp     = (op_q == OP_MOV) ? src_q : dst_q;
  assign rd_ff  = (i_rf_rd == 8'hFF);
  assign rd_00  = (i_rf_rd == 8'h00);
  assign is_inc = (op_q == OP_INC);
  assign is_dec = (op_q == OP_DEC);
  assign bad    = (int'(i_cmd_dst) >= NPAIRS) ||
                  ((i_cmd_op == OP_MOV) &&
                   (int'(i_cmd_src) >= NPAIRS));

  assign o_cmd_ready = (state_q == IDLE);
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_wrap      = wrap_q;

  // Register-file port: byte select and data for the current phase
  always_comb begin
    o_rf_load     = 1'b0;
    o_rf_load_sel = 4'd0;
    o_rf_rd_sel   = 4'd0;
    o_rf_dat      = 8'd0;
    unique case (state_q)
      LO: begin
        o_rf_load     = 1'b1;
        o_rf_load_sel = {dst_q, 1'b0};
        o_rf_rd_sel   = {rp, 1'b0};
        unique case (op_q)
          OP_INC:  o_rf_dat = i_rf_rd + 8'd1;
          OP_DEC:  o_rf_dat = i_rf_rd - 8'd1;
          OP_LDI:  o_rf_dat = imm_q[7:0];
          default: o_rf_dat = i_rf_rd;
        endcase
      end
      HI: begin
        o_rf_load     = 1'b1;
        o_rf_load_sel = {dst_q, 1'b1};
        o_rf_rd_sel   = {rp, 1'b1};
        unique case (op_q)
          OP_INC:  o_rf_dat = i_rf_rd + {7'd0, cy_q};
          OP_DEC:  o_rf_dat = i_rf_rd - {7'd0, cy_q};
          OP_LDI:  o_rf_dat = imm_q[15:8];
          default: o_rf_dat = i_rf_rd;
        endcase
      end
      default: ;
    endcase
  end

  // Sequencer next state, command latch and carry/status flags
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    src_d   = src_q;
    imm_d   = imm_q;
    cy_d    = cy_q;
    err_d   = err_q;
    wrap_d  = wrap_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          op_d    = i_cmd_op;
          dst_d   = i_cmd_dst;
          src_d   = i_cmd_src;
          imm_d   = i_cmd_imm;
          cy_d    = 1'b0;
          wrap_d  = 1'b0;
          err_d   = bad;
          done_d  = bad;
          state_d = bad ? DONE : LO;
        end
      end
      LO: begin
        cy_d    = (is_inc && rd_ff) ||
                  (is_dec && rd_00);
        state_d = HI;
      end
      HI: begin
        wrap_d  = cy_q &&
                  ((is_inc && rd_ff) ||
                   (is_dec && rd_00));
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: begin
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      dst_q   <= 3'd0;
      src_q   <= 3'd0;
      imm_q   <= 16'd0;
      cy_q    <= 1'b0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      imm_q   <= imm_d;
      cy_q    <= cy_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_regpair_seq.sv
// tb_regpair_seq: random and directed register-pair commands
// checked against a 16-bit pair model.
module tb_regpair_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [1:0]  op = 2'b00;
  logic [2:0]  dst = 3'd0;
  logic [2:0]  src = 3'd0;
  logic [15:0] imm = 16'd0;
  logic        done;
  logic        err;
  logic        wrap;
  logic [7:0]  rf_dat;
  logic        rf_load;
  logic [3:0]  rf_load_sel;
  logic [3:0]  rf_rd_sel;
  logic [7:0]  rf_rd;

  logic [7:0]  rf [16];
  logic [15:0] mp [8];

  logic        bd_we = 1'b0;
  logic [2:0]  bd_pair = 3'd0;
  logic [15:0] bd_val = 16'd0;

  int total = 0;
  int bad = 0;
  int load_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int acc_q [$];

  regpair_seq #(.NPAIRS(6)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_cmd_valid   (valid),
    .o_cmd_ready   (ready),
    .i_cmd_op      (op),
    .i_cmd_dst     (dst),
    .i_cmd_src     (src),
    .i_cmd_imm     (imm),
    .o_done        (done),
    .o_err         (err),
    .o_wrap        (wrap),
    .o_rf_dat      (rf_dat),
    .o_rf_load     (rf_load),
    .o_rf_load_sel (rf_load_sel),
    .o_rf_rd_sel   (rf_rd_sel),
    .i_rf_rd       (rf_rd)
  );

  always #5 clk = ~clk;

  assign rf_rd = rf[rf_rd_sel];

  // Register file plus a backdoor for presetting pairs
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_load) begin
      rf[rf_load_sel] <= rf_dat;
      load_cnt <= load_cnt + 1;
    end
    if (bd_we) begin
      rf[{bd_pair, 1'b0}] <= bd_val[7:0];
      rf[{bd_pair, 1'b1}] <= bd_val[15:8];
    end
    if (done) done_cnt <= done_cnt + 1;
    if (valid && ready) acc_q.push_back(cyc);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_pair(input int p, input logic [15:0] v);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_pair = 3'(p);
    bd_val  = v;
    mp[p]   = v;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic cmp_pairs(input string tag);
    for (int p = 0; p < 6; p++)
      check($sformatf("%s_p%0d", tag, p),
            {16'd0, rf[2*p+1], rf[2*p]},
            {16'd0, mp[p]});
  endtask

  task automatic run_cmd(input logic [1:0] c_op,
                         input logic [2:0] c_dst,
                         input logic [2:0] c_src,
                         input logic [15:0] c_imm,
                         input string tag);
    bit rej;
    logic w;
    int l0, d0, k;
    rej = (c_dst >= 3'd6) ||
          (c_op == 2'b11 && c_src >= 3'd6);
    w = 1'b0;
    if (!rej) begin
      case (c_op)
        2'b00: begin
          w = (mp[c_dst] == 16'hFFFF);
          mp[c_dst] = mp[c_dst] + 16'd1;
        end
        2'b01: begin
          w = (mp[c_dst] == 16'h0000);
          mp[c_dst] = mp[c_dst] - 16'd1;
        end
        2'b10: mp[c_dst] = c_imm;
        default: mp[c_dst] = mp[c_src];
      endcase
    end
    l0 = load_cnt;
    d0 = done_cnt;
    @(negedge clk);
    check({tag, "_rdy0"}, 32'(ready), 32'd1);
    valid = 1'b1;
    op    = c_op;
    dst   = c_dst;
    src   = c_src;
    imm   = c_imm;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    k = 1;
    while (!done && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 32'(k), rej ? 32'd1 : 32'd3);
    check({tag, "_err"}, 32'(err), 32'(rej));
    check({tag, "_wrap"}, 32'(wrap), 32'(w));
    @(negedge clk);
    check({tag, "_done1"}, 32'(done), 32'd0);
    check({tag, "_rdy1"}, 32'(ready), 32'd1);
    check({tag, "_loads"}, 32'(load_cnt - l0),
          rej ? 32'd0 : 32'd2);
    check({tag, "_dcnt"}, 32'(done_cnt - d0), 32'd1);
    cmp_pairs(tag);
  endtask

  initial begin
    int a0, d0;
    logic [1:0] r_op;
    logic [2:0] r_dst, r_src;

    for (int i = 0; i < 16; i++) rf[i] = 8'd0;
    for (int i = 0; i < 8; i++) mp[i] = 16'd0;

    #1;
    check("rst_rdy", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_rf", {19'd0, rf_load, rf_load_sel,
                     rf_rd_sel, rf_dat}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int p = 0; p < 6; p++) set_pair(p, 16'(p * 16'h1111));

    set_pair(5, 16'h12FF);
    run_cmd(2'b00, 3'd5, 3'd0, 16'd0, "inc5");
    set_pair(0, 16'hFFFF);
    run_cmd(2'b00, 3'd0, 3'd0, 16'd0, "inc0wrap");
    set_pair(1, 16'h0000);
    run_cmd(2'b01, 3'd1, 3'd0, 16'd0, "dec1wrap");
    set_pair(1, 16'h0100);
    run_cmd(2'b01, 3'd1, 3'd0, 16'd0, "dec1");
    run_cmd(2'b10, 3'd4, 3'd0, 16'hBEEF, "ldi4");
    run_cmd(2'b11, 3'd2, 3'd4, 16'd0, "mov24");
    run_cmd(2'b11, 3'd2, 3'd2, 16'd0, "mov22");
    run_cmd(2'b10, 3'd6, 3'd0, 16'h5555, "ldi6");
    run_cmd(2'b11, 3'd1, 3'd7, 16'd0, "mov17");

    // Held valid: one accept per four cycles
    set_pair(3, 16'h00FE);
    a0 = acc_q.size();
    @(negedge clk);
    valid = 1'b1;
    op    = 2'b00;
    dst   = 3'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("b2b_mid", {16'd0, rf[7], rf[6]}, 32'h00FF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    mp[3] = 16'h0100;
    check("b2b_acc", 32'(acc_q.size() - a0), 32'd2);
    if (acc_q.size() - a0 >= 2)
      check("b2b_gap", 32'(acc_q[a0+1] - acc_q[a0]), 32'd4);
    cmp_pairs("b2b");

    // Reset while the high byte is pending
    set_pair(3, 16'h00FF);
    @(negedge clk);
    valid = 1'b1;
    op    = 2'b00;
    dst   = 3'd3;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("arst_load", 32'(rf_load), 32'd0);
    check("arst_rdy", 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mp[3] = 16'h0000;
    check("arst_pair", {16'd0, rf[7], rf[6]}, 32'h0000);
    check("arst_done", 32'(done_cnt - d0), 32'd0);
    check("arst_rdy2", 32'(ready), 32'd1);
    cmp_pairs("arst");

    // Random commands
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: set_pair($urandom_range(0, 5), 16'hFFFF);
          1: set_pair($urandom_range(0, 5), 16'h0000);
          default: set_pair($urandom_range(0, 5), 16'($urandom));
        endcase
      end
      r_op  = 2'($urandom_range(0, 3));
      r_dst = 3'($urandom_range(0, 7));
      r_src = 3'($urandom_range(0, 7));
      run_cmd(r_op, r_dst, r_src, 16'($urandom),
              $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
